dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache that serves the load/store unit's cache port (the responder to the LS memory stage's `cache_rd`/`cache_wr` initiator). It returns zero-wait read hits and refills 4-word lines from a word-wide backing-memory port. It forwards every store to memory.

## Interface
- `LINES`, 16: number of lines. Power of two, minimum 2. Line size is 16 bytes (4 words); index is `addr[3+log2(LINES):4]`; tag is the remaining upper bits.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cache_rd` in 1: read request; held stable until completion.
- `cache_wr` in 1: write request; held stable until completion.
- `cache_addr` in 32: byte address; `[1:0]` ignored.
- `cache_wr_data` in 32: store data.
- `cache_wr_be` in 4: byte enables, bit n is byte n.
- `cache_data` out 32: read data, valid only in a read completion cycle, 0 otherwise.
- `cache_waitrequest` out 1: high stalls the initiator; a request completes in the cycle it is asserted with waitrequest low.
- `mem_rd` out 1: backing read request.
- `mem_wr` out 1: backing write request.
- `mem_addr` out 32: word-aligned backing address.
- `mem_wr_data` out 32: backing write data.
- `mem_wr_be` out 4: backing byte enables.
- `mem_rd_data` in 32: backing read data.
- `mem_rd_valid` in 1: one pulse per accepted read, returned in request order.
- `mem_waitrequest` in 1: backing stall; a request is accepted when `mem_rd|mem_wr` is high and this input is low.

## Operation
- Storage: per line a valid bit, a tag and 4×32 data words, all in flops with asynchronous read. Reset clears all valid bits; data and tags are not reset.
- IDLE state:
  - `cache_wr` takes priority when both requests are asserted; that case is illegal and the bench asserts on it.
  - On `cache_wr`, go to WRITE.
  - On `cache_rd` hit, drive `cache_waitrequest=0` and `cache_data=word[addr[3:2]]`, and stay in IDLE.
  - On `cache_rd` miss, latch the line address, clear the indexed valid bit, zero both counters and go to FILL.
- WRITE state:
  - Drive `mem_wr=1`, `mem_addr={cache_addr[31:2],2'b00}`, and pass `cache_wr_data` and `cache_wr_be` through to memory.
  - On the cycle `mem_waitrequest=0`, drive `cache_waitrequest=0` and go to IDLE.
  - On that same edge, if the access hits, merge the enabled bytes into the line.
  - A write miss does not allocate.
- FILL state:
  - Assert `mem_rd` while the request counter (2 bits plus done flag) is below 4; `mem_addr={line_addr,req_cnt,2'b00}`.
  - `req_cnt` increments on each accepted read.
  - Each `mem_rd_valid` writes `mem_rd_data` into word `rsp_cnt` and increments `rsp_cnt`.
  - On the 4th response, write the tag, set the valid bit and go to IDLE. The held request then hits there.
- `mem_rd_valid` outside FILL is ignored.
- The backing memory is reset together with this block, so no stale responses cross a reset.
- `cache_waitrequest` is 1 in all other cycles, including IDLE with no request.

## Timing
- Reset values:
  - State IDLE.
  - `cache_waitrequest=1`, `cache_data=0`.
  - `mem_rd=0`, `mem_wr=0`, `mem_addr=0`, `mem_wr_data=0`, `mem_wr_be=0`.
  - Counters 0.
- Reset asserted mid-FILL or mid-WRITE aborts the operation at the next edge; the partially filled line stays invalid.
- Read hit completes in 0 wait cycles, in the cycle of presentation.
- Read miss:
  - 1 cycle for miss detection.
  - FILL lasts until the 4th `mem_rd_valid`.
  - Completion in IDLE on the following cycle.
  - Minimum 6 cycles with zero-wait memory and 1-cycle read latency.
- Write: minimum 2 cycles (IDLE plus WRITE with `mem_waitrequest=0`).
- Read addresses issue in order +0, +4, +8, +12. Up to 4 reads may be outstanding.
- A response may arrive in the same cycle as a later request is accepted; both counters update on that edge.

## Configuration
- `DCACHE_STATS_EN`:
  - Defined: adds output ports `stat_reads` (32) and `stat_misses` (32), both reset to 0.
  - `stat_reads` increments on every read completion; `stat_misses` increments on every IDLE→FILL transition.
  - Both counters wrap at 2^32.
  - Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Read miss then hit:
  - Stimulus: after reset, read 0x100; memory returns D0..D3.
  - Required: `mem_rd` issued to 0x100, 0x104, 0x108, 0x10C in that order; completion with `cache_data=D0`.
  - Follow-up: read 0x108 completes in the same cycle with D2 and no `mem_rd`.
- Write hit with partial byte enables:
  - Stimulus: write 0x104, data 0xAABBCCDD, be 0011.
  - Required: one `mem_wr` at 0x104 with be 0011; a following read of 0x104 returns `{D1[31:16],16'hCCDD}` with 0 waits.
- Write miss does not allocate:
  - Stimulus: write 0x2000.
  - Required: exactly one `mem_wr`, no `mem_rd`; a following read of 0x2000 misses and fills from 0x2000.
- Conflict eviction with `LINES=16`:
  - Stimulus: read 0x100, read 0x200, read 0x100.
  - Required: three fills in total; each read returns its own memory word.
- Backpressure:
  - Stimulus: `mem_waitrequest` high 3 cycles per request; read latency 5.
  - Required: `cache_waitrequest` stays high throughout; `mem_addr` is held stable while stalled; correct data on completion.
- Reset mid-fill:
  - Stimulus: assert `reset` after 2 responses.
  - Required: reset values on the next cycle; a re-read of the same address performs a full 4-word fill.

Source files
------------

// File: rtl/dcache_if.sv
// dcache bus interfaces.
//   dcache_if     : load/store unit <-> cache request port
//   dcache_mem_if : cache <-> word-wide backing memory port
// Optional feature macro used by the cache: DCACHE_STATS_EN.

interface dcache_if;
   logic        cache_rd;
   logic        cache_wr;
   logic [31:0] cache_addr;
   logic [31:0] cache_wr_data;
   logic [3:0]  cache_wr_be;
   logic [31:0] cache_data;
   logic        cache_waitrequest;

   // Load/store unit side: issues requests, holds them until waitrequest drops
   modport master (
      output cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
      input  cache_data, cache_waitrequest
   );

   // Cache side: responds to requests
   modport slave (
      input  cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
      output cache_data, cache_waitrequest
   );
endinterface

interface dcache_mem_if;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_be;
   logic [31:0] mem_rd_data;
   logic        mem_rd_valid;
   logic        mem_waitrequest;

   // Cache side: issues backing reads and writes
   modport master (
      output mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
      input  mem_rd_data, mem_rd_valid, mem_waitrequest
   );

   // Backing memory side
   modport slave (
      input  mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
      output mem_rd_data, mem_rd_valid, mem_waitrequest
   );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
// 16-byte lines (4 words), zero-wait read hits, line refill over a
// word-wide backing port with up to 4 reads outstanding, every store
// forwarded to memory.
// Optional feature: define DCACHE_STATS_EN to add the stat_reads and
// stat_misses counter outputs.

module dcache #(
   parameter int LINES = 16
) (
   input  logic          clock,
   input  logic          reset,
   dcache_if.slave       cpu,
   dcache_mem_if.master  mem
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]   stat_reads,
   output logic [31:0]   stat_misses
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_FILL  = 2'd2
   } state_t;

   state_t             state_q;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [31:0]        data_q [LINES][4];
   logic [27:0]        line_addr_q;
   logic [2:0]         req_cnt_q;   // bit 2 set once all four reads are accepted
   logic [1:0]         rsp_cnt_q;

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic [1:0]         word;
   logic [IDX_W-1:0]   fill_idx;
   logic [TAG_W-1:0]   fill_tag;
   logic               hit;
   logic               rd_hit;
   logic               wr_done;
   logic               rd_accept;
   logic               rsp_fire;
   logic               fill_last;
   logic               unused_addr_bits;

   // Merge the enabled bytes of a store into an existing word
   function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   assign idx      = cpu.cache_addr[4 +: IDX_W];
   assign tag      = cpu.cache_addr[31 -: TAG_W];
   assign word     = cpu.cache_addr[3:2];
   assign fill_idx = line_addr_q[IDX_W-1:0];
   assign fill_tag = line_addr_q[27 -: TAG_W];

   // Byte offset bits are ignored; stores are word-addressed with byte enables
   assign unused_addr_bits = ^cpu.cache_addr[1:0];

   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign rd_hit    = (state_q == S_IDLE) && cpu.cache_rd && !cpu.cache_wr && hit;
   assign wr_done   = (state_q == S_WRITE) && !mem.mem_waitrequest;
   assign rd_accept = (state_q == S_FILL) && !req_cnt_q[2] && !mem.mem_waitrequest;
   assign rsp_fire  = (state_q == S_FILL) && mem.mem_rd_valid;
   assign fill_last = rsp_fire && (rsp_cnt_q == 2'd3);

   // Output decode: read hits answer in the presentation cycle, so outputs follow state and inputs directly
   always_comb begin
      cpu.cache_waitrequest = 1'b1;
      cpu.cache_data        = '0;
      mem.mem_rd            = 1'b0;
      mem.mem_wr            = 1'b0;
      mem.mem_addr          = '0;
      mem.mem_wr_data       = '0;
      mem.mem_wr_be         = '0;
      case (state_q)
         S_IDLE: begin
            if (rd_hit) begin
               cpu.cache_waitrequest = 1'b0;
               cpu.cache_data        = data_q[idx][word];
            end
         end
         S_WRITE: begin
            mem.mem_wr      = 1'b1;
            mem.mem_addr    = {cpu.cache_addr[31:2], 2'b00};
            mem.mem_wr_data = cpu.cache_wr_data;
            mem.mem_wr_be   = cpu.cache_wr_be;
            if (!mem.mem_waitrequest) cpu.cache_waitrequest = 1'b0;
         end
         S_FILL: begin
            if (!req_cnt_q[2]) begin
               mem.mem_rd   = 1'b1;
               mem.mem_addr = {line_addr_q, req_cnt_q[1:0], 2'b00};
            end
         end
         default: ;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] stat_reads_q;
   logic [31:0] stat_misses_q;
   assign stat_reads  = stat_reads_q;
   assign stat_misses = stat_misses_q;
`endif

   // Controller: state, valid bits, refill counters and the latched line address
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         valid_q   <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
`ifdef DCACHE_STATS_EN
         stat_reads_q  <= '0;
         stat_misses_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cpu.cache_wr) begin
                  state_q <= S_WRITE;
               end else if (cpu.cache_rd) begin
                  if (!hit) begin
                     // Invalidate up front so a partial refill never looks valid
                     line_addr_q  <= cpu.cache_addr[31:4];
                     valid_q[idx] <= 1'b0;
                     req_cnt_q    <= '0;
                     rsp_cnt_q    <= '0;
                     state_q      <= S_FILL;
`ifdef DCACHE_STATS_EN
                     stat_misses_q <= stat_misses_q + 32'd1;
`endif
                  end
`ifdef DCACHE_STATS_EN
                  else begin
                     stat_reads_q <= stat_reads_q + 32'd1;
                  end
`endif
               end
            end
            S_WRITE: begin
               if (!mem.mem_waitrequest) state_q <= S_IDLE;
            end
            S_FILL: begin
               if (rd_accept) req_cnt_q <= req_cnt_q + 3'd1;
               if (rsp_fire)  rsp_cnt_q <= rsp_cnt_q + 2'd1;
               if (fill_last) begin
                  valid_q[fill_idx] <= 1'b1;
                  state_q           <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Line storage: refill words, tag on completion, byte merge on store hits
   always_ff @(posedge clock) begin
      if (rsp_fire) data_q[fill_idx][rsp_cnt_q] <= mem.mem_rd_data;
      if (fill_last) tag_q[fill_idx] <= fill_tag;
      if (wr_done && hit) begin
         data_q[idx][word] <= merge_be(data_q[idx][word], cpu.cache_wr_data, cpu.cache_wr_be);
      end
   end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios followed by
// randomized reads/writes, checked against a line-residency and
// memory-image reference model. Handles DCACHE_STATS_EN builds too.

module tb_dcache;

   localparam int LINES = 16;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   dcache_if     cif ();
   dcache_mem_if mif ();

`ifdef DCACHE_STATS_EN
   logic [31:0] stat_reads;
   logic [31:0] stat_misses;
`endif

   dcache #(.LINES(LINES)) dut (
      .clock (clock),
      .reset (reset),
      .cpu   (cif.slave),
      .mem   (mif.master)
`ifdef DCACHE_STATS_EN
      ,
      .stat_reads  (stat_reads),
      .stat_misses (stat_misses)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // ---------------- backing memory model ----------------
   typedef struct {
      logic [31:0] data;
      int unsigned due;
   } rsp_t;

   logic [31:0] bmem [logic [31:0]];
   rsp_t        rsp_q[$];
   logic [31:0] rd_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   logic [3:0]  wr_be_log[$];
   int unsigned stall_n = 0;
   int unsigned lat_n   = 1;
   int unsigned stall_cnt = 0;
   int unsigned cyc = 0;
   int unsigned rsp_given = 0;
   logic        stalled_prev = 1'b0;
   logic [31:0] stalled_addr = '0;

   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return init_word(a);
   endfunction

   initial begin
      mif.mem_waitrequest = 1'b0;
      mif.mem_rd_valid    = 1'b0;
      mif.mem_rd_data     = '0;
   end

   always @(negedge clock) begin
      cyc++;
      mif.mem_waitrequest = (stall_cnt < stall_n);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         mif.mem_rd_valid = 1'b1;
         mif.mem_rd_data  = rsp_q[0].data;
         void'(rsp_q.pop_front());
         rsp_given++;
      end else begin
         mif.mem_rd_valid = 1'b0;
         mif.mem_rd_data  = $urandom;
      end
      #1;
      if (mif.mem_rd || mif.mem_wr) begin
         if (stalled_prev) check_val("mem_addr_hold", mif.mem_addr, stalled_addr);
         if (mif.mem_waitrequest) begin
            stall_cnt++;
            stalled_prev = 1'b1;
            stalled_addr = mif.mem_addr;
         end else begin
            stall_cnt    = 0;
            stalled_prev = 1'b0;
            if (mif.mem_rd) begin
               rd_log.push_back(mif.mem_addr);
               rsp_q.push_back('{data: bmem_rd(mif.mem_addr), due: cyc + lat_n});
            end
            if (mif.mem_wr) begin
               wr_addr_log.push_back(mif.mem_addr);
               wr_data_log.push_back(mif.mem_wr_data);
               wr_be_log.push_back(mif.mem_wr_be);
               bmem[mif.mem_addr] = merge_bytes(bmem_rd(mif.mem_addr), mif.mem_wr_data, mif.mem_wr_be);
            end
         end
      end else begin
         stalled_prev = 1'b0;
      end
   end

   always @(posedge clock) begin
      if (reset) begin
         rsp_q.delete();
         stall_cnt    = 0;
         stalled_prev = 1'b0;
      end
   end

   always @(posedge clock) begin
      if (reset === 1'b0)
         assert (!(cif.cache_rd && cif.cache_wr)) else $error("illegal simultaneous cache_rd and cache_wr");
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [logic [31:0]];
   logic [27:0] res_line  [LINES];
   logic        res_valid [LINES];
   int          fills = 0;
   int unsigned exp_reads = 0;
   int unsigned exp_misses = 0;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      if (ref_mem.exists(k)) return ref_mem[k];
      return init_word(k);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
      exp_reads  = 0;
      exp_misses = 0;
   endtask

   task automatic check_reset_outputs();
      check_val("rst_waitreq",  {31'd0, cif.cache_waitrequest}, 32'd1);
      check_val("rst_data",     cif.cache_data, 32'd0);
      check_val("rst_mem_rd",   {31'd0, mif.mem_rd}, 32'd0);
      check_val("rst_mem_wr",   {31'd0, mif.mem_wr}, 32'd0);
      check_val("rst_mem_addr", mif.mem_addr, 32'd0);
      check_val("rst_wr_data",  mif.mem_wr_data, 32'd0);
      check_val("rst_wr_be",    {28'd0, mif.mem_wr_be}, 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, output int waits, output logic [31:0] got);
      logic [27:0] line;
      int          idx;
      logic        exp_hit;
      logic        done;
      logic        nz;
      line    = addr[31:4];
      idx     = int'(line % LINES);
      exp_hit = res_valid[idx] && (res_line[idx] == line);
      waits   = 0;
      got     = '0;
      done    = 1'b0;
      nz      = 1'b0;
      @(negedge clock);
      rd_log.delete();
      wr_addr_log.delete();
      cif.cache_rd   = 1'b1;
      cif.cache_addr = addr;
      for (int c = 0; c < 400 && !done; c++) begin
         #1;
         if (!cif.cache_waitrequest) begin
            done = 1'b1;
            got  = cif.cache_data;
         end else begin
            waits++;
            if (cif.cache_data != 0) nz = 1'b1;
            @(negedge clock);
         end
      end
      @(negedge clock);
      cif.cache_rd = 1'b0;
      check_val("rd_complete", {31'd0, done}, 32'd1);
      check_val("rd_data", got, ref_rd(addr));
      check_val("rd_data_zero_while_waiting", {31'd0, nz}, 32'd0);
      check_val("rd_no_mem_wr", wr_addr_log.size(), 32'd0);
      if (exp_hit) begin
         check_val("hit_waits", waits, 32'd0);
         check_val("hit_no_mem_rd", rd_log.size(), 32'd0);
      end else begin
         check_val("fill_reads", rd_log.size(), 32'd4);
         for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check_val("fill_addr", rd_log[i], {line, 4'b0000} + 32'(4 * i));
         if (rd_log.size() == 4) fills++;
         exp_misses++;
      end
      exp_reads++;
      res_line[idx]  = line;
      res_valid[idx] = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      logic [31:0] k;
      int          waits;
      logic        done;
      k     = {addr[31:2], 2'b00};
      waits = 0;
      done  = 1'b0;
      @(negedge clock);
      rd_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      wr_be_log.delete();
      cif.cache_wr      = 1'b1;
      cif.cache_addr    = addr;
      cif.cache_wr_data = data;
      cif.cache_wr_be   = be;
      for (int c = 0; c < 400 && !done; c++) begin
         #1;
         if (!cif.cache_waitrequest) done = 1'b1;
         else begin
            waits++;
            @(negedge clock);
         end
      end
      @(negedge clock);
      cif.cache_wr = 1'b0;
      check_val("wr_complete", {31'd0, done}, 32'd1);
      check_val("wr_waits", waits, 32'(1 + stall_n));
      check_val("wr_no_mem_rd", rd_log.size(), 32'd0);
      check_val("wr_count", wr_addr_log.size(), 32'd1);
      if (wr_addr_log.size() > 0) begin
         check_val("wr_addr", wr_addr_log[0], k);
         check_val("wr_data", wr_data_log[0], data);
         check_val("wr_be", {28'd0, wr_be_log[0]}, {28'd0, be});
      end
      ref_mem[k] = merge_bytes(ref_rd(k), data, be);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, observed time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      int          base_fills;
      int unsigned base_rsp;
      logic [31:0] got;
      logic [31:0] d1;
      logic [31:0] a;

      reset             = 1'b1;
      cif.cache_rd      = 1'b0;
      cif.cache_wr      = 1'b0;
      cif.cache_addr    = '0;
      cif.cache_wr_data = '0;
      cif.cache_wr_be   = '0;
      clear_model();
      repeat (3) @(negedge clock);
      #1;
      check_reset_outputs();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_val("idle_waitreq", {31'd0, cif.cache_waitrequest}, 32'd1);

      // Read miss then hit, zero-wait memory with 1-cycle latency
      stall_n = 0;
      lat_n   = 1;
      do_read(32'h100, w, got);
      check_val("miss_latency", w, 32'd6);
      do_read(32'h108, w, got);

      // Write hit with partial byte enables
      do_write(32'h104, 32'hAABB_CCDD, 4'b0011);
      do_read(32'h104, w, got);
      d1 = init_word(32'h104);
      check_val("partial_merge", got, {d1[31:16], 16'hCCDD});

      // Write miss does not allocate
      do_write(32'h2000, 32'h1357_9BDF, 4'b1111);
      base_fills = fills;
      do_read(32'h2000, w, got);
      check_val("write_miss_no_alloc", fills - base_fills, 32'd1);

      // Conflict eviction
      base_fills = fills;
      do_read(32'h100, w, got);
      do_read(32'h200, w, got);
      do_read(32'h100, w, got);
      check_val("conflict_fills", fills - base_fills, 32'd3);

      // Backpressure
      stall_n = 3;
      lat_n   = 5;
      do_read(32'h404, w, got);
      do_read(32'h40C, w, got);
      do_write(32'h408, 32'hCAFE_F00D, 4'b1100);
      do_read(32'h408, w, got);

      // Reset mid-fill
      stall_n  = 0;
      lat_n    = 2;
      @(negedge clock);
      base_rsp       = rsp_given;
      cif.cache_rd   = 1'b1;
      cif.cache_addr = 32'h300;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         #1;
         if (rsp_given - base_rsp >= 2) break;
      end
      check_val("midfill_two_rsps", {31'd0, (rsp_given - base_rsp >= 2)}, 32'd1);
      @(negedge clock);
      reset        = 1'b1;
      cif.cache_rd = 1'b0;
      @(negedge clock);
      #1;
      check_reset_outputs();
      @(negedge clock);
      reset = 1'b0;
      clear_model();
      base_fills = fills;
      do_read(32'h300, w, got);
      check_val("refill_after_reset", fills - base_fills, 32'd1);

      // Randomized traffic over a small address pool to force hits and conflicts
      for (int n = 0; n < 250; n++) begin
         a = ($urandom_range(0, 2) << 12) | ($urandom_range(0, 3) << 4) |
             ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         stall_n = $urandom_range(0, 2);
         lat_n   = $urandom_range(1, 4);
         if ($urandom_range(0, 9) < 3) do_write(a, $urandom, 4'($urandom_range(0, 15)));
         else                          do_read(a, w, got);
      end

`ifdef DCACHE_STATS_EN
      check_val("stat_reads", stat_reads, exp_reads);
      check_val("stat_misses", stat_misses, exp_misses);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
